// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter, LSB first, valid/ready on both sides, one-word holding buffer.
// Optional serial_last output enabled by defining PARALLEL_TO_SERIAL_LAST_EN.
module parallel_to_serial #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
`ifdef PARALLEL_TO_SERIAL_LAST_EN
  output logic             serial_last,
`endif
  input  logic             serial_ready
);

  localparam int unsigned CW = $clog2(width);
  localparam logic [CW-1:0] CNT_MAX = CW'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] hbuf_q, hbuf_d;
  logic             hbuf_valid_q, hbuf_valid_d;
  logic             p_fire, s_fire, last_bit;

  // Outputs come straight from state flops.
  assign serial_valid   = (state_q == SHIFT);
  assign serial_data    = shreg_q[0];
  assign parallel_ready = !hbuf_valid_q;
`ifdef PARALLEL_TO_SERIAL_LAST_EN
  assign serial_last    = (state_q == SHIFT) && (cnt_q == '0);
`endif

  assign p_fire   = parallel_valid && !hbuf_valid_q;
  assign s_fire   = (state_q == SHIFT) && serial_ready;
  assign last_bit = s_fire && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= CNT_MAX;
      hbuf_q       <= '0;
      hbuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hbuf_q       <= hbuf_d;
      hbuf_valid_q <= hbuf_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    hbuf_d       = hbuf_q;
    hbuf_valid_d = hbuf_valid_q;
    unique case (state_q)
      IDLE: begin
        if (p_fire) begin
          shreg_d = parallel_data;
          cnt_d   = CNT_MAX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (hbuf_valid_q) begin
            shreg_d      = hbuf_q;
            cnt_d        = CNT_MAX;
            hbuf_valid_d = 1'b0;
          end else if (p_fire) begin
            shreg_d = parallel_data;
            cnt_d   = CNT_MAX;
          end else begin
            state_d = IDLE;
          end
        end else if (s_fire) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q - CW'(1);
        end
        // A word arriving while one is still shifting waits in the buffer.
        if (p_fire && !last_bit) begin
          hbuf_d       = parallel_data;
          hbuf_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized self-checking bench for parallel_to_serial: a queue of pending bits
// predicts every output, and received bits are reassembled into words in order.
module tb_parallel_to_serial;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;
  logic         parallel_ready;
  logic         serial_valid;
  logic         serial_data;
  logic         serial_ready;
`ifdef PARALLEL_TO_SERIAL_LAST_EN
  logic         serial_last;
`endif

  parallel_to_serial #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
    .parallel_ready (parallel_ready),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    .serial_last    (serial_last),
`endif
    .serial_ready   (serial_ready)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  bit           bitq[$];
  logic [W-1:0] src[$];
  logic [W-1:0] sent[$];
  logic [W-1:0] rx_word;
  int           rx_cnt;
  bit           last_acc;
  bit           sv_seen;
  bit           sd_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow from the number of bits still owed downstream.
  task automatic check_outputs();
    int r, n;
    r = bitq.size();
    n = (r + int'(W) - 1) / int'(W);
    check("serial_valid", 32'(serial_valid), 32'(r > 0));
    check("parallel_ready", 32'(parallel_ready), 32'(n < 2));
    if (r > 0) check("serial_data", 32'(serial_data), 32'(bitq[0]));
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    check("serial_last", 32'(serial_last), 32'((r > 0) && (r % int'(W) == 1)));
`endif
    sv_seen = serial_valid;
    sd_seen = serial_data;
  endtask

  task automatic clear_model();
    bitq.delete();
    sent.delete();
    src.delete();
    rx_cnt   = 0;
    last_acc = 1'b0;
  endtask

  task automatic cycle();
    int  n;
    bit  pf, sf;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      n  = (bitq.size() + int'(W) - 1) / int'(W);
      sf = serial_ready && (bitq.size() > 0);
      pf = parallel_valid && (n < 2);
      if (sv_seen && serial_ready) begin
        rx_word[rx_cnt] = sd_seen;
        rx_cnt++;
        if (rx_cnt == int'(W)) begin
          rx_cnt = 0;
          if (sent.size() > 0) check("rx_word", 32'(rx_word), 32'(sent.pop_front()));
          else check("rx_unexpected", 32'(rx_word), 32'hffff_ffff);
        end
      end
      if (sf) void'(bitq.pop_front());
      if (pf) begin
        for (int i = 0; i < int'(W); i++) bitq.push_back(parallel_data[i]);
        sent.push_back(parallel_data);
      end
      last_acc = pf;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Valid is held with stable data until the model sees it accepted.
  task automatic run(input int cycles, input int pv_pct, input int sr_pct, input bit alt);
    for (int c = 0; c < cycles; c++) begin
      if (!parallel_valid || last_acc) begin
        if (src.size() > 0 && int'($urandom_range(99)) < pv_pct) begin
          parallel_valid = 1'b1;
          parallel_data  = src.pop_front();
        end else begin
          parallel_valid = 1'b0;
        end
      end
      if (alt) serial_ready = (c % 2 == 0);
      else     serial_ready = int'($urandom_range(99)) < sr_pct;
      cycle();
    end
  endtask

  initial begin
    rst            = 1'b1;
    parallel_valid = 1'b0;
    parallel_data  = '0;
    serial_ready   = 1'b0;
    clear_model();
    #1;
    check("rst_serial_valid", 32'(serial_valid), 32'd0);
    check("rst_serial_data", 32'(serial_data), 32'd0);
    check("rst_parallel_ready", 32'(parallel_ready), 32'd1);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    src.push_back(8'hA5);
    run(12, 100, 100, 1'b0);

    src.push_back(8'h3C);
    src.push_back(8'hF0);
    run(22, 100, 100, 1'b0);

    src.push_back(8'h81);
    run(20, 100, 0, 1'b1);

    src.push_back(8'hFF);
    src.push_back(8'h00);
    run(4, 100, 100, 1'b0);
    parallel_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_serial_valid", 32'(serial_valid), 32'd0);
    check("midrst_serial_data", 32'(serial_data), 32'd0);
    check("midrst_parallel_ready", 32'(parallel_ready), 32'd1);
    cycle();
    rst = 1'b0;
    run(3, 0, 100, 1'b0);
    src.push_back(8'h55);
    run(12, 100, 100, 1'b0);

    for (int i = 0; i < 200; i++) src.push_back(W'($urandom));
    run(4000, 70, 60, 1'b0);
    run(40, 100, 100, 1'b0);
    check("all_words_sent", 32'(src.size()), 32'd0);
    check("all_words_received", 32'(sent.size()), 32'd0);
    check("no_partial_word", 32'(rx_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Converts multi-bit parallel words into a single-bit serial stream, LSB first. It sits directly upstream of serial_to_parallel, so a word passed through both blocks arrives with every bit in its original position. Input and output both use valid/ready handshakes. A one-word holding buffer sustains back-to-back words with no idle cycle between them.

Parameters:
width, 8, parallel word width in bits; legal range is width >= 2.

Ports:
clk  input  1  clock; all state updates on posedge clk.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
parallel_valid  input  1  upstream word available.
parallel_data  input  width  upstream word.
parallel_ready  output  1  block can accept a word this cycle.
serial_valid  output  1  serial_data holds a valid bit.
serial_data  output  1  current serial bit.
serial_ready  input  1  downstream accepts the bit this cycle.

Behaviour:
- Handshake definitions:
  - p_fire = parallel_valid && parallel_ready.
  - s_fire = serial_valid && serial_ready.
- Internal state:
  - shift register shreg[width-1:0].
  - bit counter cnt, width $clog2(width), counting down from width-1.
  - busy flag.
  - holding buffer hbuf[width-1:0] with flag hbuf_valid.
- Reset values (async, on rst high):
  - busy=0, hbuf_valid=0, cnt=width-1, shreg=0, hbuf=0.
  - Therefore serial_valid=0, serial_data=0, parallel_ready=1.
- Combinational outputs:
  - serial_valid = busy.
  - serial_data = shreg[0].
  - parallel_ready = !hbuf_valid.
- States: IDLE (busy=0) and SHIFT (busy=1).
- IDLE:
  - On p_fire, load parallel_data into shreg, set cnt=width-1 and busy=1.
  - The first bit is on serial_data the cycle after acceptance (latency 1).
- SHIFT, s_fire with cnt != 0: shift shreg right by one, decrement cnt.
- SHIFT, s_fire with cnt == 0 (last bit leaving):
  - If hbuf_valid: load hbuf into shreg, set cnt=width-1, clear hbuf_valid. Any p_fire on the same edge is impossible, since parallel_ready=0.
  - Else if p_fire: load parallel_data directly into shreg, set cnt=width-1.
  - Else: busy=0.
- SHIFT, p_fire not consumed by the last-bit case above: store parallel_data in hbuf, set hbuf_valid=1.
- SHIFT without s_fire: shreg, cnt and serial_data hold. serial_valid never drops while a word is in flight, and data stays stable under backpressure.
- Throughput:
  - With serial_ready held high and upstream always valid, serial_valid stays 1 continuously: width bits every width cycles, no bubbles.
  - parallel_ready drops for at most width-1 cycles per word once the buffer fills.
- Boundary conditions:
  - Buffer full and shifter busy: parallel_ready=0; upstream must hold its word.
  - Simultaneous last-bit s_fire and p_fire with empty buffer: the direct load above applies; the word does not pass through hbuf.
  - rst mid-word: the word in flight and the buffered word are discarded. Serial output resumes only with the next accepted word. Partial words are never completed.
- Arithmetic: cnt compares against 0 and reloads to width-1; no wrap-around below 0 ever occurs.

Optional Feature:
Macro: PARALLEL_TO_SERIAL_LAST_EN.
- Defined:
  - Adds output port serial_last (1 bit), equal to busy && (cnt == 0), marking the final bit of each word.
  - Reset value is 0.
  - Lets a downstream frame checker resynchronise.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Single word, width=8, serial_ready=1: accept 8'hA5 at cycle 0 -> serial_data = 1,0,1,0,0,1,0,1 on cycles 1..8, then serial_valid=0 at cycle 9; parallel_ready=1 throughout.
2. Back-to-back: present 8'h3C then 8'hF0 continuously, serial_ready=1 -> 16 consecutive valid bits 0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1 with no gap; parallel_ready=0 while hbuf is full.
3. Backpressure: 8'h81, with serial_ready low on every odd cycle -> each bit holds while stalled; exactly 8 s_fires yield 1,0,0,0,0,0,0,1.
4. Reset mid-operation: assert rst after 3 bits of 8'hFF, with 8'h00 buffered -> outputs go to reset values immediately; no remaining 1s or buffered 0s appear; the next word 8'h55 serialises cleanly.
5. Loopback into serial_to_parallel (width=8), random 200 words with random serial_ready -> each parallel_data out equals the input word, in order.
6. width=2 with PARALLEL_TO_SERIAL_LAST_EN defined: words 2'b10, 2'b01 -> serial_data 0,1,1,0; serial_last high on the 2nd and 4th valid bits only.
